// File: rtl/gcm_block_feeder_if.sv
// Word-stream input, tag-ready strobe and packed-block output of the GCM block feeder.
interface gcm_block_feeder_if;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_first;
    logic         s_last;
    logic [288:0] s_bypass;
    logic         i_tag_ready;
    logic [0:127] o_plain_text;
    logic [288:0] o_bypass_text;
    logic         o_valid;
    logic         o_new;
    logic         o_last;
    logic         o_err;
    logic [15:0]  o_msg_count;

    modport master (
        output s_valid, s_data, s_first, s_last, s_bypass, i_tag_ready,
        input  s_ready, o_plain_text, o_bypass_text, o_valid, o_new, o_last, o_err, o_msg_count
    );

    modport slave (
        input  s_valid, s_data, s_first, s_last, s_bypass, i_tag_ready,
        output s_ready, o_plain_text, o_bypass_text, o_valid, o_new, o_last, o_err, o_msg_count
    );
endinterface

// File: rtl/gcm_block_feeder.sv
// Packs 32-bit message words into zero-padded 128-bit GCM blocks with new/last/bypass sideband.
// Block is emitted one cycle after its completing word; one-cycle bubble per block.
// s_ready drops during the emit bubble and while waiting for the tag of the finished message.
module gcm_block_feeder #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int TAG_TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    gcm_block_feeder_if.slave bus
);
    localparam int            TW        = $clog2(TAG_TIMEOUT);
    localparam logic [1:0]    LANE_LAST = 2'(WORDS_PER_BLOCK - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TAG_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, WAIT_TAG} state_t;
    typedef logic [0:3][31:0] blk_t;

    state_t        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    blk_t          buf_q, buf_d;
    logic          first_q, first_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          new_q, new_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    blk_t          plain_q, plain_d;
    logic [288:0]  byp_q, byp_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          xfer;
    logic          take;
    logic [1:0]    lane;
    blk_t          blk;

    assign xfer = bus.s_valid && ready_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        first_d = first_q;
        timer_d = timer_q;
        valid_d = 1'b0;
        new_d   = 1'b0;
        last_d  = 1'b0;
        plain_d = plain_q;
        byp_d   = byp_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        lane    = lane_q;
        blk     = buf_q;

        case (state_q)
            IDLE, FILL: begin
                if (xfer) begin
                    if (bus.s_first) begin
                        // A first word inside a message drops the partial block and restarts from here
                        err_d   = err_q | (state_q == FILL);
                        byp_d   = bus.s_bypass;
                        first_d = 1'b1;
                        lane    = '0;
                        blk     = '0;
                        take    = 1'b1;
                    end else if (state_q == FILL) begin
                        take = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (take) begin
                    blk[lane] = bus.s_data;
                    if (bus.s_last || (lane == LANE_LAST)) begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                        new_d   = first_d;
                        last_d  = bus.s_last;
                        plain_d = blk;
                        first_d = 1'b0;
                        lane_d  = '0;
                        buf_d   = '0;
                    end else begin
                        state_d = FILL;
                        lane_d  = lane + 2'd1;
                        buf_d   = blk;
                    end
                end
            end
            EMIT: begin
                timer_d = '0;
                state_d = last_q ? WAIT_TAG : FILL;
            end
            WAIT_TAG: begin
                // Tag arriving on the expiry cycle still counts as success
                if (bus.i_tag_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            buf_q   <= '0;
            first_q <= 1'b0;
            timer_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            plain_q <= '0;
            byp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            last_q  <= last_d;
            err_q   <= err_d;
            plain_q <= plain_d;
            byp_q   <= byp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s_ready       = ready_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_new         = new_q;
    assign bus.o_last        = last_q;
    assign bus.o_err         = err_q;
    assign bus.o_plain_text  = plain_q;
    assign bus.o_bypass_text = byp_q;
    assign bus.o_msg_count   = cnt_q;
endmodule

// File: tb/tb_gcm_block_feeder.sv
// Bench for gcm_block_feeder: cycle table, directed corner sequences, random messages vs a message-level model.
module tb_gcm_block_feeder;
    localparam int TMO = 16;
    localparam logic [288:0] BYP_A = {1'b1, {9{32'hA5A5_0001}}};
    localparam logic [288:0] BYP_B = {1'b0, {9{32'h5A5A_1234}}};
    localparam logic [127:0] P0 = 128'h0;
    localparam logic [127:0] P1 = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] P2 = 128'h00000005_00000006_00000007_00000008;
    localparam logic [127:0] P3 = 128'hDEADBEEF_00000000_00000000_00000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcm_block_feeder_if ifc ();
    gcm_block_feeder #(.WORDS_PER_BLOCK(4), .TAG_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [288:0] act, input logic [288:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Message-level reference model: expected blocks, sticky error, completed-message count
    typedef struct {
        logic [127:0] dat;
        bit           is_new;
        bit           is_last;
        logic [288:0] byp;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] pend[$];
    bit          m_in_msg, m_first, m_err;
    logic [15:0] m_cnt;
    logic [288:0] m_byp;

    function automatic void model_reset();
        exp_q.delete();
        pend.delete();
        m_in_msg = 0; m_first = 0; m_err = 0; m_cnt = '0; m_byp = '0;
    endfunction

    function automatic void model_accept(logic [31:0] w, bit f, bit l, logic [288:0] b);
        exp_t e;
        if (f) begin
            if (m_in_msg) m_err = 1;
            pend.delete();
            m_in_msg = 1; m_first = 1; m_byp = b;
        end else if (!m_in_msg) begin
            m_err = 1;
            return;
        end
        pend.push_back(w);
        if (pend.size() == 4 || l) begin
            e.dat = '0;
            for (int i = 0; i < 4; i++) begin
                e.dat = e.dat << 32;
                if (i < pend.size()) e.dat = e.dat | 128'(pend[i]);
            end
            e.is_new = m_first; e.is_last = l; e.byp = m_byp;
            exp_q.push_back(e);
            m_first = 0;
            pend.delete();
            if (l) m_in_msg = 0;
        end
    endfunction

    // Tag sampled d edges after the last word: one EMIT edge, then a TMO-cycle window
    function automatic void model_tag(int d);
        if (d >= 2 && d <= TMO + 1) m_cnt = m_cnt + 16'd1;
        else m_err = 1;
    endfunction

    bit   mon_en = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en && ifc.o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_block: o_valid 1 data %h want no block", ifc.o_plain_text);
            end else begin
                mon_e = exp_q.pop_front();
                chk("blk_data", ifc.o_plain_text, mon_e.dat);
                chk("blk_new", ifc.o_new, mon_e.is_new);
                chk("blk_last", ifc.o_last, mon_e.is_last);
                chk("blk_bypass", ifc.o_bypass_text, mon_e.byp);
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit f, input bit l, input logic [288:0] b);
        int w = 0;
        @(negedge clk);
        ifc.s_valid = 1'b1; ifc.s_data = d; ifc.s_first = f; ifc.s_last = l; ifc.s_bypass = b;
        while (ifc.s_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ifc.s_ready !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: s_ready %b want 1", ifc.s_ready);
            ifc.s_valid = 1'b0;
            return;
        end
        model_accept(d, f, l, b);
        @(posedge clk);
        #1 ifc.s_valid = 1'b0;
    endtask

    task automatic tag_after(input int d);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            ifc.i_tag_ready = (i == d);
            @(posedge clk);
        end
        #1 ifc.i_tag_ready = 1'b0;
        model_tag(d);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (ifc.s_ready !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("idle_ready", ifc.s_ready, 1'b1);
        chk("err", ifc.o_err, m_err);
        chk("msg_count", ifc.o_msg_count, m_cnt);
        chk("sb_drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ifc.s_valid = 1'b0; ifc.i_tag_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", ifc.s_ready, 1'b0);
        chk("rst_valid", ifc.o_valid, 1'b0);
        chk("rst_new", ifc.o_new, 1'b0);
        chk("rst_last", ifc.o_last, 1'b0);
        chk("rst_err", ifc.o_err, 1'b0);
        chk("rst_plain", ifc.o_plain_text, '0);
        chk("rst_bypass", ifc.o_bypass_text, '0);
        chk("rst_count", ifc.o_msg_count, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_exit_ready", ifc.s_ready, 1'b1);
    endtask

    typedef struct {
        bit v; logic [31:0] d; bit f; bit l; bit tag; logic [288:0] b;
        bit e_rdy; bit e_vld; bit e_new; bit e_last; logic [127:0] e_plain; logic [288:0] e_byp;
        bit e_err; logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit v, logic [31:0] d, bit f, bit l, bit tag, logic [288:0] b,
                                bit rdy, bit vld, bit nw, bit ls, logic [127:0] p,
                                logic [288:0] eb, bit er, logic [15:0] c);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.l = l; t.tag = tag; t.b = b;
        t.e_rdy = rdy; t.e_vld = vld; t.e_new = nw; t.e_last = ls; t.e_plain = p;
        t.e_byp = eb; t.e_err = er; t.e_cnt = c;
        tbl.push_back(t);
    endfunction

    initial begin
        int len, rs;
        logic [288:0] byp;
        rst = 1'b1;
        ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.s_first = 1'b0; ifc.s_last = 1'b0;
        ifc.s_bypass = '0; ifc.i_tag_ready = 1'b0;

        // 8-word message, tag 10 cycles after last word, single-word message, stray word
        add(1, 32'h1, 1, 0, 0, BYP_A, 1, 0, 0, 0, P0, BYP_A, 0, 0);
        add(1, 32'h2, 0, 0, 0, BYP_B, 1, 0, 0, 0, P0, BYP_A, 0, 0);
        add(1, 32'h3, 0, 0, 0, BYP_B, 1, 0, 0, 0, P0, BYP_A, 0, 0);
        add(1, 32'h4, 0, 0, 0, BYP_B, 0, 1, 1, 0, P1, BYP_A, 0, 0);
        add(1, 32'h5, 0, 0, 0, BYP_B, 1, 0, 0, 0, P1, BYP_A, 0, 0);
        add(1, 32'h5, 0, 0, 0, BYP_B, 1, 0, 0, 0, P1, BYP_A, 0, 0);
        add(1, 32'h6, 0, 0, 0, BYP_B, 1, 0, 0, 0, P1, BYP_A, 0, 0);
        add(1, 32'h7, 0, 0, 0, BYP_B, 1, 0, 0, 0, P1, BYP_A, 0, 0);
        add(1, 32'h8, 0, 1, 0, BYP_B, 0, 1, 0, 1, P2, BYP_A, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 32'hBAD, 0, 0, 0, BYP_B, 0, 0, 0, 0, P2, BYP_A, 0, 0);
        add(0, 32'h0, 0, 0, 1, BYP_B, 1, 0, 0, 0, P2, BYP_A, 0, 1);
        add(0, 32'h0, 0, 0, 1, BYP_B, 1, 0, 0, 0, P2, BYP_A, 0, 1);
        add(1, 32'hDEADBEEF, 1, 1, 0, BYP_B, 0, 1, 1, 1, P3, BYP_B, 0, 1);
        add(0, 32'h0, 0, 0, 0, BYP_A, 0, 0, 0, 0, P3, BYP_B, 0, 1);
        add(0, 32'h0, 0, 0, 1, BYP_A, 1, 0, 0, 0, P3, BYP_B, 0, 2);
        add(1, 32'h77, 0, 0, 0, BYP_A, 1, 0, 0, 0, P3, BYP_B, 1, 2);
        add(0, 32'h0, 0, 0, 0, BYP_A, 1, 0, 0, 0, P3, BYP_B, 1, 2);

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            ifc.s_valid = tbl[i].v; ifc.s_data = tbl[i].d; ifc.s_first = tbl[i].f;
            ifc.s_last = tbl[i].l; ifc.i_tag_ready = tbl[i].tag; ifc.s_bypass = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_ready", i), ifc.s_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_valid", i), ifc.o_valid, tbl[i].e_vld);
            chk($sformatf("t%0d_new", i), ifc.o_new, tbl[i].e_new);
            chk($sformatf("t%0d_last", i), ifc.o_last, tbl[i].e_last);
            chk($sformatf("t%0d_plain", i), ifc.o_plain_text, tbl[i].e_plain);
            chk($sformatf("t%0d_bypass", i), ifc.o_bypass_text, tbl[i].e_byp);
            chk($sformatf("t%0d_err", i), ifc.o_err, tbl[i].e_err);
            chk($sformatf("t%0d_count", i), ifc.o_msg_count, tbl[i].e_cnt);
        end
        @(negedge clk);
        ifc.s_valid = 1'b0; ifc.i_tag_ready = 1'b0;

        // Restart on the third word: partial dropped, new block begins with the restarting word
        mon_en = 1;
        do_reset();
        send(32'h11, 1, 0, BYP_A);
        send(32'h22, 0, 0, BYP_A);
        send(32'h33, 1, 0, BYP_B);
        send(32'h44, 0, 0, BYP_A);
        send(32'h55, 0, 0, BYP_A);
        send(32'h66, 0, 1, BYP_A);
        tag_after(3);
        wait_idle();

        // Tag on the expiry cycle succeeds; one cycle later it is too late; tag during EMIT is ignored
        do_reset();
        send(32'hC0FFEE01, 1, 1, BYP_A);
        tag_after(TMO + 1);
        wait_idle();
        send(32'hC0FFEE02, 1, 1, BYP_B);
        tag_after(TMO + 2);
        wait_idle();
        send(32'hC0FFEE03, 1, 1, BYP_A);
        tag_after(1);
        wait_idle();

        // Timeout: back to IDLE exactly TMO cycles after entering WAIT_TAG
        do_reset();
        send(32'hDEADBEEF, 1, 1, BYP_B);
        for (int i = 1; i <= TMO + 1; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tmo%0d_ready", i), ifc.s_ready, (i == TMO + 1));
            chk($sformatf("tmo%0d_err", i), ifc.o_err, (i == TMO + 1));
        end
        m_err = 1;
        wait_idle();

        // Random messages with stray words, restarts, gaps and varied tag delays
        for (int m = 0; m < 40; m++) begin
            byp = '0;
            for (int k = 0; k < 10; k++) byp = (byp << 32) | 289'($urandom);
            if ($urandom_range(0, 7) == 0) send($urandom, 0, 1'($urandom_range(0, 1)), ~byp);
            len = $urandom_range(1, 9);
            rs = (len > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : 0;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send($urandom, (k == 0) || (rs != 0 && k == rs), (k == len - 1),
                     (rs != 0 && k >= rs) ? ~byp : byp);
            end
            tag_after($urandom_range(1, 20));
            wait_idle();
        end

        // Reset after two words: nothing emitted, then a clean 4-word message
        send(32'hAAAA0001, 1, 0, BYP_A);
        send(32'hAAAA0002, 0, 0, BYP_A);
        do_reset();
        send(32'hBBBB0001, 1, 0, BYP_B);
        send(32'hBBBB0002, 0, 0, BYP_A);
        send(32'hBBBB0003, 0, 0, BYP_A);
        send(32'hBBBB0004, 0, 1, BYP_A);
        tag_after(5);
        wait_idle();

        chk("final_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/gcm_block_feeder.md
# gcm_block_feeder

Upstream stage of the GCM AES API wrapper. It accepts a message as a stream of 32-bit words with a valid/ready handshake and packs every four words into one 128-bit plaintext block, zero-padding the final block. It drives the wrapper's new/last strobes and 289-bit bypass sideband. It admits a new message only after the previous message's tag is reported ready.

## Interface
- WORDS_PER_BLOCK, 4, 32-bit words per 128-bit block; fixed at 4, other values unsupported.
- TAG_TIMEOUT, 1024, cycles to wait in WAIT_TAG for the tag before abandoning; must be ≥ 2.

Ports:
- clk  in  1  Clock; single clock domain.
- rst  in  1  Synchronous, active-high reset.
- s_valid  in  1  Input word valid.
- s_ready  out  1  Feeder can accept a word this cycle.
- s_data  in  32  Input word; the first word of a block lands in plaintext bits [0:31].
- s_first  in  1  Qualifies the first word of a message.
- s_last  in  1  Qualifies the last word of a message.
- s_bypass  in  289  Sideband, sampled on the accepted s_first word.
- i_tag_ready  in  1  Tag-ready pulse from the GCM wrapper.
- o_plain_text  out  [0:127]  Packed plaintext block.
- o_bypass_text  out  [288:0]  Captured sideband, held for the whole message.
- o_valid  out  1  One-cycle pulse: o_plain_text is valid.
- o_new  out  1  With o_valid, marks the first block of a message; drives the wrapper's i_new.
- o_last  out  1  With o_valid, marks the last block of a message; drives the wrapper's i_last.
- o_err  out  1  Sticky protocol-error flag; cleared only by rst.
- o_msg_count  out  16  Count of completed messages; wraps 0xFFFF→0.

## Operation
- A transfer occurs when s_valid and s_ready are both high.
- States and behaviour:
  - IDLE: s_ready=1.
    - An accepted word with s_first=0 is dropped and sets o_err.
    - An accepted word with s_first=1 captures s_bypass, stores the word in lane 0, and goes to FILL. If s_last is also high, it goes to EMIT instead.
  - FILL: s_ready=1. The accepted word goes to the next lane (0..3).
    - Lane 3 filled or s_last seen → EMIT.
    - An accepted s_first in FILL sets o_err. The partial block is discarded and never emitted. That word then restarts the message as in IDLE.
  - EMIT: s_ready=0.
    - Registers o_valid=1. o_new=1 iff this is the message's first block. o_last=1 iff s_last was seen.
    - Unfilled lanes are zero.
    - Next state is WAIT_TAG if this is the last block, otherwise FILL.
  - WAIT_TAG: s_ready=0. The timeout counter counts up from 0.
    - i_tag_ready=1 → o_msg_count increments, go to IDLE.
    - Counter reaches TAG_TIMEOUT-1 → set o_err, go to IDLE; o_msg_count does not increment.
- i_tag_ready outside WAIT_TAG is ignored.
- o_bypass_text is constant from capture until the next accepted s_first.
- Lane counter: 2 bits, cleared on EMIT and on a restart.

## Timing
- Reset values: s_ready=0 during rst, then 1 in the first cycle after rst deasserts (IDLE).
- Outputs o_valid, o_new, o_last, o_err at reset: 0.
- Outputs o_plain_text, o_bypass_text, o_msg_count at reset: 0.
- All outputs are registered.
- Latency: o_valid is asserted the cycle after the word that completes the block (4th word or s_last) is accepted.
- Full-rate throughput: 4 words per 5 cycles (one EMIT bubble).
- o_valid, o_new and o_last are single-cycle pulses. o_plain_text holds its value until the next EMIT.
- Single-block message: o_new and o_last are both high in the same o_valid cycle.
- Reset mid-operation: the partial block, captured bypass, timeout and lane counter are discarded. No o_valid is emitted.
- s_valid with s_ready=0 is not a transfer; the source must hold its data.
- i_tag_ready arriving in the same cycle the timeout expires counts as success: no o_err, and the count increments.

## Test plan
- Message of 8 words 0x00000001..0x00000008 (first on word 1, last on word 8); pulse i_tag_ready 10 cycles later:
  - Block 0x00000001_00000002_00000003_00000004 with o_new=1, o_last=0.
  - Block 0x…05_…06_…07_…08 with o_new=0, o_last=1, each emitted the cycle after its 4th word.
  - o_msg_count=1.
- Message of 1 word 0xDEADBEEF with s_first=s_last=1:
  - One block 0xDEADBEEF_00000000_00000000_00000000 with o_new=o_last=1.
  - o_bypass_text equals the s_bypass value sampled on that word.
- Word with s_first=0 in IDLE → no o_valid; o_err=1. A following s_first message is processed normally.
- s_first on the 3rd word of a message:
  - The 2-word partial is never emitted; o_err=1.
  - The new message's first block starts with the restarting word.
- No i_tag_ready after the last block, TAG_TIMEOUT=16: return to IDLE exactly 16 cycles after entering WAIT_TAG; o_err=1; o_msg_count unchanged.
- rst asserted after 2 words of a block: no o_valid; all outputs 0 next cycle. A new 4-word message afterwards emits correctly.
